// File: rtl/obuf_mem_ctrl.sv
// -----------------------------------------------------------------------------
// obuf_mem_ctrl
//   Memory-side sequencer for the output buffer (OBUF). Runs one command at a
//   time:
//     DRAIN (cmd_op=0): read cmd_count OBUF words starting at cmd_base_addr and
//                       stream them out on rd_out_* (valid/ready, last flag).
//     LOAD  (cmd_op=1): accept cmd_count words on wr_in_* (valid/ready) and
//                       write them into OBUF starting at cmd_base_addr.
//   The OBUF read port has a fixed 1-cycle latency. A 2-entry skid FIFO plus a
//   single in-flight flag absorb that latency so rd_out_ready can stall at any
//   time without losing or duplicating words.
//
// Ports
//   clk, reset                    clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_op, cmd_base_addr,        command fields; count 0 completes at once
//   cmd_count
//   mem_read_req/addr/data        OBUF read port (data 1 cycle after req)
//   mem_write_req/addr/data       OBUF write port (registered)
//   rd_out_valid/ready/data/last  DRAIN output stream
//   wr_in_valid/ready/data        LOAD input stream
//   busy                          high in any state other than IDLE
//   done                          one-cycle completion pulse
// -----------------------------------------------------------------------------
module obuf_mem_ctrl #(
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int COUNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_op,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [COUNT_W-1:0]        cmd_count,

    output logic                      mem_read_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [MEM_DATA_WIDTH-1:0] mem_read_data,

    output logic                      mem_write_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_write_data,

    output logic                      rd_out_valid,
    input  logic                      rd_out_ready,
    output logic [MEM_DATA_WIDTH-1:0] rd_out_data,
    output logic                      rd_out_last,

    input  logic                      wr_in_valid,
    output logic                      wr_in_ready,
    input  logic [MEM_DATA_WIDTH-1:0] wr_in_data,

    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0]        CNT_ONE  = COUNT_W'(1);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = MEM_ADDR_WIDTH'(1);

    state_t state, state_nxt;

    // Command context
    logic [MEM_ADDR_WIDTH-1:0] addr_ptr;
    logic [COUNT_W-1:0]        remaining;   // words still to issue / accept
    logic [COUNT_W-1:0]        cmd_cnt;     // latched command length
    logic [COUNT_W-1:0]        pop_cnt;     // DRAIN words delivered so far

    // Read-latency skid buffer
    logic                                 inflight;
    logic [1:0][MEM_DATA_WIDTH-1:0]       fifo_mem;
    logic                                 fifo_wr;
    logic                                 fifo_rd;
    logic [1:0]                           fifo_cnt;

    logic accept;
    logic fifo_empty;
    logic head_valid;
    logic pop;
    logic last_word;
    logic room;
    logic issue;
    logic push;
    logic fifo_pop;
    logic wr_hs;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    assign accept     = cmd_valid && cmd_ready;
    assign fifo_empty = (fifo_cnt == 2'd0);

    // The word returning from OBUF this cycle is visible at the stream head
    // when the FIFO is empty, so the first word appears one cycle after issue
    // and an empty-FIFO pop bypasses storage entirely.
    assign head_valid = (state == S_DRAIN) && (!fifo_empty || inflight);
    assign pop        = head_valid && rd_out_ready;
    assign last_word  = (pop_cnt == cmd_cnt - CNT_ONE);

    // Words held = FIFO occupancy + word in flight; never more than two.
    assign room  = ({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2;
    assign issue = (state == S_DRAIN) && (remaining != '0) && (room || pop);

    // Returning word is stored unless it was consumed directly via bypass.
    assign push     = inflight && !(fifo_empty && pop);
    assign fifo_pop = pop && !fifo_empty;

    assign wr_hs = wr_in_valid && wr_in_ready;

    assign mem_read_addr = addr_ptr;
    assign rd_out_data   = fifo_empty ? mem_read_data : fifo_mem[fifo_rd];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_count == '0) state_nxt = S_DONE;
                    else if (cmd_op)     state_nxt = S_LOAD;
                    else                 state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: if (pop && last_word) state_nxt = S_DONE;
            // remaining==0 with a strobe pending means the final write is on
            // the port this cycle.
            S_LOAD:  if ((remaining == '0) && mem_write_req) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        wr_in_ready  = 1'b0;
        mem_read_req = 1'b0;
        rd_out_valid = 1'b0;
        rd_out_last  = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_DRAIN: begin
                mem_read_req = issue;
                rd_out_valid = head_valid;
                rd_out_last  = head_valid && last_word;
            end
            S_LOAD:  wr_in_ready = (remaining != '0);
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Command context, skid FIFO and write port registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_ptr       <= '0;
            remaining      <= '0;
            cmd_cnt        <= '0;
            pop_cnt        <= '0;
            inflight       <= 1'b0;
            fifo_mem       <= '0;
            fifo_wr        <= 1'b0;
            fifo_rd        <= 1'b0;
            fifo_cnt       <= 2'd0;
            mem_write_req  <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
        end else begin
            mem_write_req <= wr_hs;
            if (wr_hs) begin
                mem_write_addr <= addr_ptr;
                mem_write_data <= wr_in_data;
            end

            if (accept) begin
                addr_ptr  <= cmd_base_addr;
                remaining <= cmd_count;
                cmd_cnt   <= cmd_count;
                pop_cnt   <= '0;
                inflight  <= 1'b0;
                fifo_wr   <= 1'b0;
                fifo_rd   <= 1'b0;
                fifo_cnt  <= 2'd0;
            end else begin
                // issue and wr_hs belong to different states, never both.
                if (issue || wr_hs) begin
                    addr_ptr  <= addr_ptr + ADDR_ONE;
                    remaining <= remaining - CNT_ONE;
                end

                if (pop) pop_cnt <= pop_cnt + CNT_ONE;

                inflight <= issue;

                if (push) begin
                    fifo_mem[fifo_wr] <= mem_read_data;
                    fifo_wr           <= ~fifo_wr;
                end
                if (fifo_pop) fifo_rd <= ~fifo_rd;

                case ({push, fifo_pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                    2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obuf_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_obuf_mem_ctrl
//   Directed bench for obuf_mem_ctrl with a behavioural OBUF (1-cycle read
//   latency). Cycle k=0 is the command accept cycle; every later cycle is
//   sampled 1 ns after the falling edge, after inputs for it have been driven.
// -----------------------------------------------------------------------------
module tb_obuf_mem_ctrl;

    localparam int AW = 11;
    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [AW-1:0] cmd_base_addr = '0;
    logic [CW-1:0] cmd_count = '0;
    logic          mem_read_req;
    logic [AW-1:0] mem_read_addr;
    logic [DW-1:0] mem_read_data = '0;
    logic          mem_write_req;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;
    logic          rd_out_valid;
    logic          rd_out_ready = 1'b0;
    logic [DW-1:0] rd_out_data;
    logic          rd_out_last;
    logic          wr_in_valid = 1'b0;
    logic          wr_in_ready;
    logic [DW-1:0] wr_in_data = '0;
    logic          busy;
    logic          done;

    obuf_mem_ctrl #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base_addr(cmd_base_addr), .cmd_count(cmd_count),
        .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .rd_out_valid(rd_out_valid), .rd_out_ready(rd_out_ready),
        .rd_out_data(rd_out_data), .rd_out_last(rd_out_last),
        .wr_in_valid(wr_in_valid), .wr_in_ready(wr_in_ready),
        .wr_in_data(wr_in_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural OBUF: registered read, write on strobe.
    logic [DW-1:0] obuf [0:2047];
    always @(posedge clk) begin
        if (mem_read_req)  mem_read_data <= obuf[mem_read_addr];
        if (mem_write_req) obuf[mem_write_addr] = mem_write_data;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus state
    logic [3:0]    rdy_pat = 4'b1111;
    logic [DW-1:0] ld_data [0:7];
    int            ld_idx;
    logic          accepted;

    // Per-command observation log
    logic [AW-1:0] rd_addr_q [$];
    int            rd_cyc_q  [$];
    logic [DW-1:0] out_q     [$];
    logic          last_q    [$];
    int            out_cyc_q [$];
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            wr_cyc_q  [$];
    int            done_q    [$];
    int ready_back, busy_cnt, hs_cnt, overlap, viol, held;

    task automatic start_cmd(input logic op, input logic [AW-1:0] base,
                             input logic [CW-1:0] cnt);
        rd_addr_q.delete(); rd_cyc_q.delete();
        out_q.delete(); last_q.delete(); out_cyc_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        done_q.delete();
        ready_back = -1; busy_cnt = 0; hs_cnt = 0; overlap = 0; viol = 0;
        held = 0; ld_idx = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_base_addr = base; cmd_count = cnt;
        rd_out_ready = 1'b0;
        #1 accepted = cmd_ready;
    endtask

    // Runs cycles k=1..n after the accept and logs every observable event.
    task automatic run(input int n);
        logic p;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            cmd_valid    = 1'b0;
            rd_out_ready = rdy_pat[(k-1) % 4];
            wr_in_data   = (ld_idx < 8) ? ld_data[ld_idx] : '0;
            #1;
            p = rd_out_valid && rd_out_ready;
            if (mem_read_req && mem_write_req) overlap++;
            if (mem_read_req && held >= 2 && !p) viol++;
            if (mem_read_req) begin
                rd_addr_q.push_back(mem_read_addr); rd_cyc_q.push_back(k);
            end
            if (p) begin
                out_q.push_back(rd_out_data); last_q.push_back(rd_out_last);
                out_cyc_q.push_back(k);
            end
            if (mem_write_req) begin
                wr_addr_q.push_back(mem_write_addr);
                wr_data_q.push_back(mem_write_data);
                wr_cyc_q.push_back(k);
            end
            if (wr_in_valid && wr_in_ready) begin ld_idx++; hs_cnt++; end
            if (done) done_q.push_back(k);
            if (cmd_ready && ready_back < 0) ready_back = k;
            if (busy) busy_cnt++;
            if (mem_read_req) held++;
            if (p) held--;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({rd_out_valid, rd_out_last, mem_read_req, mem_write_req, wr_in_ready, busy, done} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 0000000",
                     {rd_out_valid, rd_out_last, mem_read_req, mem_write_req, wr_in_ready, busy, done});
        end
        n_cmp++;
        if ({mem_write_addr, mem_read_addr, mem_write_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_addr_data: got wa=%h ra=%h wd=%h want 0",
                     mem_write_addr, mem_read_addr, mem_write_data);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_release: got ready/busy=%b want 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_drain_basic();
        for (int i = 0; i < 4; i++) obuf[16 + i] = DW'(32'hA0 + i);
        rdy_pat = 4'b1111;
        start_cmd(1'b0, 11'h010, 16'd4);
        n_cmp++;
        if (accepted !== 1'b1) begin
            n_bad++; $display("FAIL drain_accept: got %b want 1", accepted);
        end
        run(8);
        n_cmp++;
        if (rd_addr_q.size() != 4 || out_q.size() != 4) begin
            n_bad++;
            $display("FAIL drain_counts: got reads=%0d outs=%0d want 4/4",
                     rd_addr_q.size(), out_q.size());
        end
        for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
            n_cmp++;
            if (rd_addr_q[i] !== AW'(16 + i) || rd_cyc_q[i] != i + 1) begin
                n_bad++;
                $display("FAIL drain_read%0d: got addr=%h cyc=%0d want addr=%h cyc=%0d",
                         i, rd_addr_q[i], rd_cyc_q[i], AW'(16 + i), i + 1);
            end
        end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== DW'(32'hA0 + i) || last_q[i] !== (i == 3) || out_cyc_q[i] != i + 2) begin
                n_bad++;
                $display("FAIL drain_out%0d: got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                         i, out_q[i], last_q[i], out_cyc_q[i], DW'(32'hA0 + i), (i == 3), i + 2);
            end
        end
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] != 6) begin
            n_bad++;
            $display("FAIL drain_done: got %0d pulses first at %0d want 1 at 6",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
        n_cmp++;
        if (ready_back != 7 || busy_cnt != 6) begin
            n_bad++;
            $display("FAIL drain_ready_busy: got ready_at=%0d busy=%0d want 7/6", ready_back, busy_cnt);
        end
    endtask

    task automatic test_drain_backpressure();
        for (int i = 0; i < 8; i++) obuf[64 + i] = DW'(32'hE0 + i);
        rdy_pat = 4'b1001;     // k=1:1, k=2:0, k=3:0, k=4:1, repeating
        start_cmd(1'b0, 11'h040, 16'd8);
        run(30);
        rdy_pat = 4'b1111;
        n_cmp++;
        if (out_q.size() != 8 || rd_addr_q.size() != 8) begin
            n_bad++;
            $display("FAIL bp_counts: got outs=%0d reads=%0d want 8/8", out_q.size(), rd_addr_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== DW'(32'hE0 + i) || last_q[i] !== (i == 7)) begin
                n_bad++;
                $display("FAIL bp_out%0d: got data=%h last=%b want data=%h last=%b",
                         i, out_q[i], last_q[i], DW'(32'hE0 + i), (i == 7));
            end
        end
        for (int i = 0; i < 8 && i < rd_addr_q.size(); i++) begin
            n_cmp++;
            if (rd_addr_q[i] !== AW'(64 + i)) begin
                n_bad++;
                $display("FAIL bp_read%0d: got %h want %h", i, rd_addr_q[i], AW'(64 + i));
            end
        end
        n_cmp++;
        if (viol != 0) begin
            n_bad++; $display("FAIL bp_issue_stall: got %0d over-issues want 0", viol);
        end
        n_cmp++;
        if (done_q.size() != 1 || out_cyc_q.size() != 8 || done_q[0] != out_cyc_q[7] + 1) begin
            n_bad++;
            $display("FAIL bp_done: got %0d pulses want 1 the cycle after the last pop", done_q.size());
        end
    endtask

    task automatic test_load_wrap();
        logic [AW-1:0] ea [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        for (int i = 0; i < 4; i++) ld_data[i] = DW'(32'hB0 + i);
        start_cmd(1'b1, 11'h7FE, 16'd4);
        run(8);
        n_cmp++;
        if (wr_addr_q.size() != 4 || rd_addr_q.size() != 0) begin
            n_bad++;
            $display("FAIL load_counts: got writes=%0d reads=%0d want 4/0", wr_addr_q.size(), rd_addr_q.size());
        end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            n_cmp++;
            if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== DW'(32'hB0 + i) || wr_cyc_q[i] != i + 2) begin
                n_bad++;
                $display("FAIL load_wr%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                         i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], ea[i], DW'(32'hB0 + i), i + 2);
            end
        end
        n_cmp++;
        if (hs_cnt != 4) begin
            n_bad++; $display("FAIL load_handshakes: got %0d want 4", hs_cnt);
        end
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] != 6) begin
            n_bad++;
            $display("FAIL load_done: got %0d pulses first at %0d want 1 at 6",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
        n_cmp++;
        if (obuf[1] !== DW'(32'hB3) || obuf[2046] !== DW'(32'hB0)) begin
            n_bad++;
            $display("FAIL load_mem: got [001]=%h [7FE]=%h want b3/b0", obuf[1], obuf[2046]);
        end
    endtask

    task automatic test_zero_count();
        for (int op = 0; op < 2; op++) begin
            start_cmd(op[0], 11'h123, 16'd0);
            run(4);
            n_cmp++;
            if (done_q.size() != 1 || done_q[0] != 1 || ready_back != 2 || busy_cnt != 1) begin
                n_bad++;
                $display("FAIL zero_op%0d_timing: got pulses=%0d ready_at=%0d busy=%0d want 1 at 1, 2, 1",
                         op, done_q.size(), ready_back, busy_cnt);
            end
            n_cmp++;
            if (rd_addr_q.size() != 0 || wr_addr_q.size() != 0 || hs_cnt != 0) begin
                n_bad++;
                $display("FAIL zero_op%0d_access: got reads=%0d writes=%0d hs=%0d want 0",
                         op, rd_addr_q.size(), wr_addr_q.size(), hs_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 8; i++) obuf[32 + i] = DW'(32'h50 + i);
        rdy_pat = 4'b0000;
        start_cmd(1'b0, 11'h020, 16'd8);
        run(4);
        n_cmp++;
        if (rd_addr_q.size() != 2 || out_q.size() != 0 || rd_out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_held: got reads=%0d outs=%0d valid=%b want 2/0/1",
                     rd_addr_q.size(), out_q.size(), rd_out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({rd_out_valid, rd_out_last, mem_read_req, mem_write_req, wr_in_ready, busy, done} !== 7'b0) begin
            n_bad++;
            $display("FAIL midrst_ctl: got %b want 0000000",
                     {rd_out_valid, rd_out_last, mem_read_req, mem_write_req, wr_in_ready, busy, done});
        end
        n_cmp++;
        if ({mem_write_addr, mem_read_addr, mem_write_data} !== '0) begin
            n_bad++;
            $display("FAIL midrst_addr_data: got wa=%h ra=%h wd=%h want 0",
                     mem_write_addr, mem_read_addr, mem_write_data);
        end
        @(negedge clk);
        reset = 1'b1;
        rdy_pat = 4'b1111;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL midrst_ready: got %b want 1", cmd_ready);
        end
        ld_data[0] = 64'hC0; ld_data[1] = 64'hC1;
        start_cmd(1'b1, 11'h100, 16'd2);
        run(6);
        n_cmp++;
        if (wr_addr_q.size() != 2 || done_q.size() != 1 || done_q[0] != 4) begin
            n_bad++;
            $display("FAIL midrst_load: got writes=%0d pulses=%0d want 2 writes, done at 4",
                     wr_addr_q.size(), done_q.size());
        end
        n_cmp++;
        if (obuf[256] !== 64'hC0 || obuf[257] !== 64'hC1) begin
            n_bad++;
            $display("FAIL midrst_mem: got %h %h want c0 c1", obuf[256], obuf[257]);
        end
    endtask

    task automatic test_back_to_back();
        int ov;
        for (int i = 0; i < 3; i++) ld_data[i] = DW'(32'hD0 + i);
        rdy_pat = 4'b1111;
        start_cmd(1'b1, 11'h200, 16'd3);
        run(6);
        ov = overlap;
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] != 5 || ready_back != 6) begin
            n_bad++;
            $display("FAIL b2b_load: got pulses=%0d ready_at=%0d want done at 5, ready at 6",
                     done_q.size(), ready_back);
        end
        start_cmd(1'b0, 11'h200, 16'd3);
        run(6);
        ov += overlap;
        n_cmp++;
        if (out_q.size() != 3) begin
            n_bad++; $display("FAIL b2b_count: got %0d want 3", out_q.size());
        end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== DW'(32'hD0 + i)) begin
                n_bad++;
                $display("FAIL b2b_data%0d: got %h want %h", i, out_q[i], DW'(32'hD0 + i));
            end
        end
        n_cmp++;
        if (ov != 0) begin
            n_bad++; $display("FAIL b2b_overlap: got %0d overlapping strobes want 0", ov);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ld_data[i] = '0;
        test_reset();
        wr_in_valid = 1'b1;
        test_drain_basic();
        test_drain_backpressure();
        test_load_wrap();
        test_zero_count();
        test_reset_mid_drain();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
